// File: rtl/pong_match_sequencer.sv
// Match-level sequencer for Pong: paces game ticks from video frames and walks a match through
// attract, serve, play, point pause and game-over, watching the datapath scores for points.
module pong_match_sequencer #(
    parameter int unsigned TICK_FRAMES  = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       GAME_CLK,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       start_btn,
    input  logic [3:0] player_score,
    input  logic [3:0] com_score,
    output logic       game_tick,
    output logic       score_clear,
    output logic [2:0] state,
    output logic [1:0] winner,
    output logic       blink
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StServe = 3'd1;
    localparam logic [2:0] StPlay  = 3'd2;
    localparam logic [2:0] StPoint = 3'd3;
    localparam logic [2:0] StOver  = 3'd4;

    localparam logic [7:0] TickLast  = 8'(TICK_FRAMES - 1);
    localparam logic [7:0] ServeLast = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] PointLast = 8'(POINT_FRAMES - 1);
    localparam logic [7:0] BlinkLast = 8'(BLINK_FRAMES - 1);
    localparam logic [3:0] WinScore  = 4'(WIN_SCORE);

    logic [2:0] btn_sync_q;
    logic       start_ev_q, start_ev_d;
    logic [2:0] state_q, state_d;
    logic [7:0] frm_q, frm_d;
    logic [7:0] tick_q, tick_d;
    logic [3:0] ps_q, cs_q;
    logic       game_tick_q, game_tick_d;
    logic       score_clear_q, score_clear_d;
    logic [1:0] winner_q, winner_d;
    logic       blink_q, blink_d;
    logic       p_chg, c_chg;

    // [0],[1] form the synchronizer; [2] delays it once more for falling-edge detection
    assign start_ev_d = btn_sync_q[2] & ~btn_sync_q[1];
    assign p_chg      = (player_score != ps_q);
    assign c_chg      = (com_score != cs_q);

    always_comb begin
        state_d       = state_q;
        frm_d         = frm_q + {7'd0, frame_start};
        tick_d        = tick_q;
        game_tick_d   = 1'b0;
        score_clear_d = 1'b0;
        winner_d      = winner_q;
        blink_d       = blink_q;
        case (state_q)
            StIdle, StOver: begin
                if (frame_start && (frm_q == BlinkLast)) begin
                    blink_d = ~blink_q;
                    frm_d   = 8'd0;
                end
                if (start_ev_q) begin
                    state_d       = StServe;
                    score_clear_d = 1'b1;
                    winner_d      = 2'b00;
                    frm_d         = 8'd0;
                end
            end
            StServe: begin
                if (frame_start && (frm_q == ServeLast)) begin
                    state_d = StPlay;
                    frm_d   = 8'd0;
                    tick_d  = 8'd0;
                end
            end
            StPlay: begin
                // A point outranks a coincident frame: no tick is issued on the way out
                if (p_chg || c_chg) begin
                    frm_d = 8'd0;
                    if (p_chg && (player_score == WinScore)) begin
                        winner_d = 2'b01;
                        state_d  = StOver;
                    end else if (c_chg && (com_score == WinScore)) begin
                        winner_d = 2'b10;
                        state_d  = StOver;
                    end else begin
                        state_d = StPoint;
                    end
                end else if (frame_start) begin
                    if (tick_q == TickLast) begin
                        game_tick_d = 1'b1;
                        tick_d      = 8'd0;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
            end
            StPoint: begin
                if (frame_start && (frm_q == PointLast)) begin
                    state_d = StServe;
                    frm_d   = 8'd0;
                end
            end
            default: begin
                state_d = StIdle;
                frm_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge GAME_CLK or negedge reset) begin
        if (!reset) begin
            btn_sync_q    <= 3'b111;
            start_ev_q    <= 1'b0;
            state_q       <= StIdle;
            frm_q         <= 8'd0;
            tick_q        <= 8'd0;
            ps_q          <= 4'd0;
            cs_q          <= 4'd0;
            game_tick_q   <= 1'b0;
            score_clear_q <= 1'b0;
            winner_q      <= 2'b00;
            blink_q       <= 1'b0;
        end else begin
            btn_sync_q    <= {btn_sync_q[1:0], start_btn};
            start_ev_q    <= start_ev_d;
            state_q       <= state_d;
            frm_q         <= frm_d;
            tick_q        <= tick_d;
            ps_q          <= player_score;
            cs_q          <= com_score;
            game_tick_q   <= game_tick_d;
            score_clear_q <= score_clear_d;
            winner_q      <= winner_d;
            blink_q       <= blink_d;
        end
    end

    assign game_tick   = game_tick_q;
    assign score_clear = score_clear_q;
    assign state       = state_q;
    assign winner      = winner_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Scoreboard bench for pong_match_sequencer: a scenario-level model predicts every output event
// (tick, clear, state change, blink toggle) with its cycle; a monitor compares as they appear.
module tb_pong_match_sequencer;

    localparam int TICK  = 2;
    localparam int SERVE = 60;
    localparam int POINT = 90;
    localparam int BLINK = 16;
    localparam int WIN   = 9;

    localparam int MIdle = 0, MServe = 1, MPlay = 2, MPoint = 3, MOver = 4;

    logic       GAME_CLK = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       start_btn = 1'b1;
    logic [3:0] player_score = 4'd0;
    logic [3:0] com_score = 4'd0;
    logic       game_tick, score_clear, blink;
    logic [2:0] state;
    logic [1:0] winner;

    pong_match_sequencer #(
        .TICK_FRAMES (TICK),
        .SERVE_FRAMES(SERVE),
        .POINT_FRAMES(POINT),
        .BLINK_FRAMES(BLINK),
        .WIN_SCORE   (WIN)
    ) dut (
        .GAME_CLK    (GAME_CLK),
        .reset       (reset),
        .frame_start (frame_start),
        .start_btn   (start_btn),
        .player_score(player_score),
        .com_score   (com_score),
        .game_tick   (game_tick),
        .score_clear (score_clear),
        .state       (state),
        .winner      (winner),
        .blink       (blink)
    );

    always #5 GAME_CLK = ~GAME_CLK;

    int cyc = 0;
    always @(posedge GAME_CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [1:0] win;
        logic       tick;
        logic       clr;
        logic       blk;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model state: match phase, frames seen since entering it, expected winner/blink
    int         mode = MIdle;
    int         ph_frames = 0;
    logic [1:0] win_exp = 2'b00;
    logic       blink_exp = 1'b0;

    task automatic push_ev(input int c, input logic tk, input logic cl);
        ev_t e;
        e.cyc  = c;
        e.st   = 3'(mode);
        e.win  = win_exp;
        e.tick = tk;
        e.clr  = cl;
        e.blk  = blink_exp;
        sb.push_back(e);
    endtask

    task automatic enter(input int m);
        mode      = m;
        ph_frames = 0;
    endtask

    task automatic model_frame(input int c);
        ph_frames++;
        case (mode)
            MIdle, MOver: if (ph_frames % BLINK == 0) begin
                blink_exp = ~blink_exp;
                push_ev(c + 1, 1'b0, 1'b0);
            end
            MServe: if (ph_frames == SERVE) begin
                enter(MPlay);
                push_ev(c + 1, 1'b0, 1'b0);
            end
            MPlay: if (ph_frames % TICK == 0) push_ev(c + 1, 1'b1, 1'b0);
            MPoint: if (ph_frames == POINT) begin
                enter(MServe);
                push_ev(c + 1, 1'b0, 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic frame();
        int c;
        @(posedge GAME_CLK);
        #1;
        frame_start = 1'b1;
        c = cyc;
        model_frame(c);
        @(posedge GAME_CLK);
        #1;
        frame_start = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge GAME_CLK);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press_start(input logic [3:0] np, input logic [3:0] nc);
        int k;
        @(posedge GAME_CLK);
        #1;
        start_btn = 1'b0;
        k = cyc;
        enter(MServe);
        win_exp = 2'b00;
        push_ev(k + 4, 1'b0, 1'b1);
        repeat (10) @(posedge GAME_CLK);
        #1;
        start_btn = 1'b1;
        player_score = np;
        com_score = nc;
    endtask

    // Only called in PLAY; a random coincident frame must not produce a tick
    task automatic score_change(input logic [3:0] np, input logic [3:0] nc);
        int   c;
        logic pch, cch;
        @(posedge GAME_CLK);
        #1;
        pch = (np != player_score);
        cch = (nc != com_score);
        player_score = np;
        com_score = nc;
        frame_start = 1'($urandom_range(0, 1));
        c = cyc;
        if (pch && int'(np) == WIN) begin
            win_exp = 2'b01;
            enter(MOver);
        end else if (cch && int'(nc) == WIN) begin
            win_exp = 2'b10;
            enter(MOver);
        end else begin
            enter(MPoint);
        end
        push_ev(c + 1, 1'b0, 1'b0);
        @(posedge GAME_CLK);
        #1;
        frame_start = 1'b0;
        repeat (2) @(posedge GAME_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, {1'b0, state}, 4'd0);
        check({tag, "_game_tick"}, {3'd0, game_tick}, 4'd0);
        check({tag, "_score_clear"}, {3'd0, score_clear}, 4'd0);
        check({tag, "_winner"}, {2'd0, winner}, 4'd0);
        check({tag, "_blink"}, {3'd0, blink}, 4'd0);
    endtask

    task automatic mid_reset();
        @(posedge GAME_CLK);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(posedge GAME_CLK);
        #1;
        reset = 1'b1;
        enter(MIdle);
        win_exp = 2'b00;
        blink_exp = 1'b0;
    endtask

    // Monitor: any visible output activity must match the next predicted event
    logic [2:0] prev_state = 3'd0;
    logic       prev_blink = 1'b0;
    always @(negedge GAME_CLK) begin
        if (reset && (game_tick || score_clear || state != prev_state || blink != prev_blink)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: cyc %0d st %0d win %0d tick %0b clr %0b blink %0b",
                         cyc, state, winner, game_tick, score_clear, blink);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.st !== state || e.win !== winner || e.tick !== game_tick ||
                    e.clr !== score_clear || e.blk !== blink) begin
                    n_bad++;
                    $display({"FAIL event: got cyc %0d st %0d win %0d tick %0b clr %0b blink %0b; ",
                              "expected cyc %0d st %0d win %0d tick %0b clr %0b blink %0b"},
                             cyc, state, winner, game_tick, score_clear, blink,
                             e.cyc, e.st, e.win, e.tick, e.clr, e.blk);
                end
            end
        end
        prev_state = state;
        prev_blink = blink;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL timeout: simulation did not complete (cyc %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge GAME_CLK);
        #1;
        check_reset_values("por");
        reset = 1'b1;

        run_frames(20);
        press_start(4'd0, 4'd0);
        run_frames(SERVE);
        run_frames(10);

        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 1) == 1) score_change(player_score + 4'd1, com_score);
            else score_change(player_score, com_score + 4'd1);
            if (i == 2) begin
                player_score = 4'd8;
                com_score = 4'd8;
            end
            run_frames(POINT);
            run_frames(SERVE);
            run_frames($urandom_range(2, 6));
        end

        score_change(4'd8, 4'd9);
        run_frames(2 * BLINK + 2);
        press_start(4'd8, 4'd8);
        run_frames(SERVE);
        run_frames(4);

        score_change(4'd9, 4'd9);
        run_frames(3);
        press_start(4'd0, 4'd0);
        run_frames(SERVE);
        run_frames(5);

        mid_reset();
        run_frames(20);
        press_start(4'd0, 4'd0);
        run_frames(SERVE);
        run_frames(4);

        repeat (5) @(posedge GAME_CLK);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predicted events never seen, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
